// File: rtl/trigger_d_arbiter_module_if.sv
// Request/data bus between N requesters and the shared D-trigger register
// sequencer; the master side drives requests, the slave side returns grants and q.
interface trigger_d_arbiter_module_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] d_bus;
  logic [N-1:0]   gnt;
  logic           load;
  logic [W-1:0]   q;
  logic [PW-1:0]  q_owner;
  logic           busy;

  modport master (output req, d_bus, input gnt, load, q, q_owner, busy);
  modport slave  (input req, d_bus, output gnt, load, q, q_owner, busy);
endinterface

// File: rtl/trigger_d_arbiter_module.sv
// Round-robin arbiter that loads one requester's data into a shared W-bit
// register, then locks it for HOLD_CYCLES cycles before arbitrating again.
module trigger_d_arbiter_module #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  trigger_d_arbiter_module_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t         state_r, state_nxt_s;
  logic [7:0]     cnt_r, cnt_nxt_s;
  logic [PW-1:0]  ptr_r, ptr_nxt_s;
  logic [PW-1:0]  win_s;
  logic [PW:0]    cand_s;
  logic           found_s;
  logic [N-1:0]   gnt_r, gnt_nxt_s;
  logic           load_r, load_nxt_s;
  logic [W-1:0]   q_r, q_nxt_s;
  logic [PW-1:0]  owner_r, owner_nxt_s;
  logic           busy_r, busy_nxt_s;

  // Round-robin search starting at ptr; candidate index wraps modulo N.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_r} + (PW+1)'(k);
      cand_s = (cand_s >= (PW+1)'(N)) ? (cand_s - (PW+1)'(N)) : cand_s;
      if (!found_s && bus.req[cand_s[PW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // State and hold-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state: a zero hold keeps the FSM in IDLE so grants can go back-to-back.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (found_s && (HOLD_CYCLES != 0)) begin
          state_nxt_s = S_HOLD;
          cnt_nxt_s   = 8'(HOLD_CYCLES - 1);
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_r != 8'd0) begin
          cnt_nxt_s = cnt_r - 8'd1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Output/datapath next values; q and q_owner move only on a load.
  always_comb begin
    gnt_nxt_s   = '0;
    load_nxt_s  = 1'b0;
    q_nxt_s     = q_r;
    owner_nxt_s = owner_r;
    ptr_nxt_s   = ptr_r;
    busy_nxt_s  = (state_nxt_s == S_HOLD);
    if ((state_r == S_IDLE) && found_s) begin
      gnt_nxt_s   = {{(N-1){1'b0}}, 1'b1} << win_s;
      load_nxt_s  = 1'b1;
      q_nxt_s     = bus.d_bus[win_s*W +: W];
      owner_nxt_s = win_s;
      ptr_nxt_s   = (win_s == PW'(N-1)) ? '0 : (win_s + PW'(1));
    end else begin
      load_nxt_s = 1'b0;
    end
  end

  // Registered outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r   <= '0;
      load_r  <= 1'b0;
      q_r     <= '0;
      owner_r <= '0;
      busy_r  <= 1'b0;
      ptr_r   <= '0;
    end else begin
      gnt_r   <= gnt_nxt_s;
      load_r  <= load_nxt_s;
      q_r     <= q_nxt_s;
      owner_r <= owner_nxt_s;
      busy_r  <= busy_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.load    = load_r;
  assign bus.q       = q_r;
  assign bus.q_owner = owner_r;
  assign bus.busy    = busy_r;
endmodule

// File: tb/tb_trigger_d_arbiter_module.sv
// Directed bench: one instance with HOLD_CYCLES=2 and one with HOLD_CYCLES=0.
module tb_trigger_d_arbiter_module;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  trigger_d_arbiter_module_if #(.N(4), .W(8)) bus_a ();
  trigger_d_arbiter_module_if #(.N(4), .W(8)) bus_z ();

  trigger_d_arbiter_module #(.N(4), .W(8), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  trigger_d_arbiter_module #(.N(4), .W(8), .HOLD_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(bus_z.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle at the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic l,
                         input logic [7:0] qv, input logic [1:0] o, input logic b);
    check_value({tag, ".gnt"},     32'(bus_a.gnt),     32'(g));
    check_value({tag, ".load"},    32'(bus_a.load),    32'(l));
    check_value({tag, ".q"},       32'(bus_a.q),       32'(qv));
    check_value({tag, ".q_owner"}, 32'(bus_a.q_owner), 32'(o));
    check_value({tag, ".busy"},    32'(bus_a.busy),    32'(b));
  endtask

  task automatic do_reset(input logic [3:0] req_after);
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.req = 4'h0;
    repeat (2) @(negedge clk);
    bus_a.req = req_after;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_a.req   = 4'hF;
    bus_a.d_bus = 32'($urandom());
    bus_z.req   = 4'h0;
    bus_z.d_bus = 32'h0;

    // Reset held low with all requests active: nothing may move.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("reset_c%0d", i), 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
      bus_a.d_bus = 32'($urandom());
    end

    // Single requester 2.
    bus_a.d_bus = 32'h00A5_0000;
    do_reset(4'b0100);
    tick();
    check_a("single_e1", 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1);
    tick();
    check_a("single_e2", 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1);
    tick();
    check_a("single_e3", 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0);
    tick();
    check_a("single_e4", 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1);

    // Round robin with all four active, grants every third edge.
    bus_a.d_bus = 32'h1312_1110;
    do_reset(4'b1111);
    for (int g = 0; g < 5; g++) begin
      tick();
      check_a($sformatf("rr_g%0d", g), 4'(1 << (g % 4)), 1'b1,
              8'(8'h10 + (g % 4)), 2'(g % 4), 1'b1);
      tick();
      check_value($sformatf("rr_g%0d_gap1.load", g), 32'(bus_a.load), 32'h0);
      tick();
      check_value($sformatf("rr_g%0d_gap2.gnt", g), 32'(bus_a.gnt), 32'h0);
      check_value($sformatf("rr_g%0d_gap2.busy", g), 32'(bus_a.busy), 32'h0);
    end

    // Request pulse confined to HOLD is lost.
    bus_a.d_bus = 32'h0000_4433;
    do_reset(4'b0001);
    tick();
    check_a("hold_e1", 4'b0001, 1'b1, 8'h33, 2'd0, 1'b1);
    bus_a.req = 4'b0010;
    tick();
    check_a("hold_e2", 4'b0000, 1'b0, 8'h33, 2'd0, 1'b1);
    tick();
    check_a("hold_e3", 4'b0000, 1'b0, 8'h33, 2'd0, 1'b0);
    bus_a.req = 4'b0000;
    tick();
    check_a("hold_e4", 4'b0000, 1'b0, 8'h33, 2'd0, 1'b0);

    // Asynchronous reset in the middle of HOLD.
    bus_a.d_bus = 32'h00A5_5A00;
    do_reset(4'b0100);
    tick();
    check_a("areset_grant", 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1);
    bus_a.req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_a("areset_now", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    bus_a.req = 4'b0110;
    rst_n = 1'b1;
    tick();
    check_a("areset_after", 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1);

    // Zero hold: back-to-back alternating grants.
    bus_a.req = 4'b0000;
    bus_z.d_bus = 32'h2322_2120;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus_z.req = 4'b0011;
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check_value($sformatf("h0_e%0d.gnt", e),  32'(bus_z.gnt),  32'(1 << (e % 2)));
      check_value($sformatf("h0_e%0d.load", e), 32'(bus_z.load), 32'h1);
      check_value($sformatf("h0_e%0d.q", e),    32'(bus_z.q),    32'(8'h20 + (e % 2)));
      check_value($sformatf("h0_e%0d.busy", e), 32'(bus_z.busy), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trigger_d_arbiter_module.md
Name: trigger_d_arbiter_module

Overview:
Round-robin arbiter and sequencer for a shared W-bit D-trigger register bank. N requesters each present data and a request. The block grants one requester at a time, loads that requester's data into the shared register, then holds the register stable for a programmable number of cycles before the next arbitration. It sits in front of the D-trigger datapath and is the only writer of that register.

Parameters:
N, 4, number of requesters (2..16)
W, 8, width of the shared D-trigger register
HOLD_CYCLES, 2, cycles the register is held after a load before re-arbitration (0..255)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request per requester, level, held until granted
d_bus  input  N*W  requester data; requester i occupies bits [i*W +: W]
gnt  output  N  one-hot grant pulse, one cycle, registered
load  output  1  one-cycle pulse, high in the cycle q takes new data
q  output  W  shared D-trigger register contents
q_owner  output  clog2(N)  index of the requester whose data is in q
busy  output  1  high while in HOLD (register locked)

Behaviour:
- Reset (rst_n=0, async, any time): gnt=0, load=0, q=0, q_owner=0, busy=0, internal ptr=0, hold counter=0, state=IDLE. All outputs take these values immediately, without waiting for a clk edge.
- Release of rst_n is sampled on clk. The first arbitration can occur at the first rising edge with rst_n=1.
- States:
  - IDLE: the arbiter samples req on every rising edge.
  - HOLD: req is ignored.
- IDLE with req==0: outputs unchanged except gnt=0 and load=0. The state stays IDLE.
- IDLE with req!=0 at rising edge T:
  - Winner w is the first index with req[w]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - At edge T, registered: gnt<=onehot(w), load<=1, q<=d_bus[w*W +: W], q_owner<=w, ptr<=(w+1) mod N.
  - If HOLD_CYCLES>0: state<=HOLD, counter<=HOLD_CYCLES-1, busy<=1.
  - If HOLD_CYCLES==0: the state stays IDLE and busy stays 0, so back-to-back grants are possible on consecutive edges.
- gnt and load are high for exactly one cycle after edge T and are cleared at edge T+1 unless a new grant occurs (HOLD_CYCLES==0 only).
- HOLD, at each edge:
  - If counter!=0: counter decrements.
  - Else: state<=IDLE, busy<=0.
  - busy is therefore high for exactly HOLD_CYCLES cycles starting at edge T.
  - The next arbitration edge is T+HOLD_CYCLES+1 for HOLD_CYCLES>0, or T+1 for HOLD_CYCLES==0.
- q and q_owner change only on a load edge or on reset. They are stable throughout HOLD and IDLE.
- Requester protocol:
  - A requester keeps req high until it sees gnt[i].
  - After gnt it may drop req or keep it high. If kept high, it re-competes and is served again only after the other active requesters, per round-robin.
  - A req pulse that falls before being sampled in IDLE is not served. No request memory is kept.
- Fairness: with all N requesters continuously active, grants cycle 0,1,...,N-1,0,... Any active requester waits at most N-1 grants.
- ptr wrap: w=N-1 gives ptr=0.
- d_bus is sampled only at the load edge. Changes at other times have no effect.
- Reset asserted mid-HOLD aborts the hold: busy=0, q=0, ptr=0. The sequence restarts from requester 0 priority.

Test Plan:
- Reset values: hold rst_n=0, drive req=4'hF and random d_bus. Required: gnt=0, load=0, q=8'h00, q_owner=0, busy=0, with no change while reset is low.
- Single requester, N=4 W=8 H=2: req=4'b0100, d_bus[2]=8'hA5 from edge 1. Required: at edge 1, gnt=4'b0100, load=1, q=8'hA5, q_owner=2, busy=1; busy falls at edge 3; the next grant to requester 2 (req still high) is at edge 4.
- Round robin, N=4 H=2: req=4'b1111 constant, d_bus[i]=8'h10+i. Required: grants at edges 1,4,7,10,13 to requesters 0,1,2,3,0; q=8'h10,8'h11,8'h12,8'h13,8'h10; ptr wraps after requester 3.
- Requests during HOLD ignored: grant requester 0 at edge 1 (H=2), then pulse req[1] high only during cycles 2-3. Required: no grant to requester 1, q stays at requester 0 data, no load pulse.
- Async reset mid-operation: during HOLD after granting requester 2, drive rst_n low between clock edges. Required: immediate q=0, busy=0, gnt=0. After release with req=4'b0110, the first grant goes to requester 1 (ptr reset to 0).
- HOLD_CYCLES=0: req=4'b0011 constant. Required: grants on consecutive edges alternating 0,1,0,1; load high every cycle; busy never asserts.
